// File: rtl/mult18x18_mac_seq_pkg.sv
// Shared constants and saturation helpers for the MULT18X18 multiply-accumulate sequencer.
package mult18x18_mac_seq_pkg;

  localparam int MULT_W    = 18;
  localparam int PROD_W    = 36;
  localparam int ACC_W_DEF = 48;
  localparam int CNT_W_DEF = 8;

  // Most positive w-bit two's-complement value, right-aligned in 64 bits.
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative w-bit value; only the low w bits are meaningful.
  function automatic logic [63:0] sat_min(input int w);
    return ~sat_max(w);
  endfunction

endpackage

// File: rtl/mult18x18_mac_seq_acc_add.sv
// Sign-extends a 36-bit product, adds it to the running sum, flags signed overflow
// and optionally clamps the result.
module mac_acc_add
  import mult18x18_mac_seq_pkg::*;
#(
  parameter int ACC_W    = ACC_W_DEF,
  parameter int SATURATE = 0
) (
  input  logic [ACC_W-1:0]  acc_in,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);

  localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(ACC_W));
  localparam logic [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(ACC_W));

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] raw;

  always_comb begin
    prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
    raw      = acc_in + prod_ext;
    ovf      = (acc_in[ACC_W-1] == prod_ext[ACC_W-1]) && (raw[ACC_W-1] != acc_in[ACC_W-1]);
    sum      = raw;
    // Overflow can only happen when both operands share a sign, so that sign picks the rail.
    if ((SATURATE != 0) && ovf) begin
      sum = acc_in[ACC_W-1] ? ACC_MIN : ACC_MAX;
    end
  end

endmodule

// File: rtl/mult18x18_mac_seq.sv
// Streaming MAC sequencer: operand register -> external MULT18X18 -> product register
// -> accumulator, emitting one result per in_last-tagged group.
module mult18x18_mac_seq
  import mult18x18_mac_seq_pkg::*;
#(
  parameter int ACC_W    = ACC_W_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int SATURATE = 0
) (
  input  logic              C,
  input  logic              CLR,
  input  logic              CE,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MULT_W-1:0] in_a,
  input  logic [MULT_W-1:0] in_b,
  input  logic              in_last,
  output logic [MULT_W-1:0] mul_a,
  output logic [MULT_W-1:0] mul_b,
  input  logic [PROD_W-1:0] mul_p,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_cnt,
  output logic              out_ovf
);

  logic [MULT_W-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic              s1_v_q, s1_v_d, s1_last_q, s1_last_d;
  logic [PROD_W-1:0] p_q, p_d;
  logic              s2_v_q, s2_v_d, s2_last_q, s2_last_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d, first_q, first_d;
  logic [ACC_W-1:0]  out_acc_q, out_acc_d;
  logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
  logic              out_ovf_q, out_ovf_d, out_valid_q, out_valid_d;

  logic              stall, adv;
  logic [ACC_W-1:0]  acc_base, add_sum;
  logic              add_ovf;
  logic [CNT_W-1:0]  cnt_sum;
  logic              ovf_sum;

  assign acc_base = first_q ? '0 : acc_q;

  mac_acc_add #(
    .ACC_W    (ACC_W),
    .SATURATE (SATURATE)
  ) u_add (
    .acc_in (acc_base),
    .prod   (p_q),
    .sum    (add_sum),
    .ovf    (add_ovf)
  );

  always_comb begin
    // Only a finished result that cannot leave blocks the pipe; partial terms keep flowing.
    stall       = out_valid_q & ~out_ready & s2_v_q & s2_last_q;
    adv         = CE & ~stall;
    cnt_sum     = (first_q ? '0 : cnt_q) + CNT_W'(1);
    ovf_sum     = (first_q ? 1'b0 : ovf_q) | add_ovf;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    s1_v_d      = s1_v_q;
    s1_last_d   = s1_last_q;
    p_d         = p_q;
    s2_v_d      = s2_v_q;
    s2_last_d   = s2_last_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    first_d     = first_q;
    out_acc_d   = out_acc_q;
    out_cnt_d   = out_cnt_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;
    if (adv) begin
      s1_v_d = in_valid;
      if (in_valid) begin
        mul_a_d   = in_a;
        mul_b_d   = in_b;
        s1_last_d = in_last;
      end
      p_d       = mul_p;
      s2_v_d    = s1_v_q;
      s2_last_d = s1_last_q;
    end
    if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (adv && s2_v_q) begin
      if (!s2_last_q) begin
        acc_d   = add_sum;
        cnt_d   = cnt_sum;
        ovf_d   = ovf_sum;
        first_d = 1'b0;
      end else begin
        out_acc_d   = add_sum;
        out_cnt_d   = cnt_sum;
        out_ovf_d   = ovf_sum;
        out_valid_d = 1'b1;
        first_d     = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
        ovf_d       = 1'b0;
      end
    end
  end

  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      s1_v_q      <= 1'b0;
      s1_last_q   <= 1'b0;
      p_q         <= '0;
      s2_v_q      <= 1'b0;
      s2_last_q   <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      first_q     <= 1'b1;
      out_acc_q   <= '0;
      out_cnt_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      s1_v_q      <= s1_v_d;
      s1_last_q   <= s1_last_d;
      p_q         <= p_d;
      s2_v_q      <= s2_v_d;
      s2_last_q   <= s2_last_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      first_q     <= first_d;
      out_acc_q   <= out_acc_d;
      out_cnt_q   <= out_cnt_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = adv;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign out_cnt   = out_cnt_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_mult18x18_mac_seq.sv
// Drives three sequencer variants (48-bit wrap, 37-bit wrap, 37-bit saturate) with one
// stimulus stream and scores every emitted result against a behavioural accumulator model.
`timescale 1ns/1ps
module tb_mult18x18_mac_seq;

  localparam int NI = 3;
  localparam int AW [NI] = '{48, 37, 37};
  localparam int SAT [NI] = '{0, 0, 1};

  typedef struct packed {
    logic [NI-1:0][63:0] acc;
    logic [NI-1:0][7:0]  cnt;
    logic [NI-1:0]       ovf;
  } exp_t;

  logic        C = 1'b0;
  logic        CLR, CE, in_valid, in_last, out_ready;
  logic [17:0] in_a, in_b;

  logic [17:0] ma [NI];
  logic [17:0] mb [NI];
  logic [35:0] mp [NI];
  logic [63:0] acc_x [NI];
  logic [7:0]  cnt_x [NI];
  logic        ovf_x [NI];
  logic        vld_x [NI];
  logic        rdy_x [NI];

  always #5 C = ~C;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    logic [AW[gi]-1:0] acc_w;
    // Behavioural stand-in for the MULT18X18 primitive.
    assign mp[gi]    = $signed(ma[gi]) * $signed(mb[gi]);
    assign acc_x[gi] = 64'($signed(acc_w));
    mult18x18_mac_seq #(.ACC_W(AW[gi]), .CNT_W(8), .SATURATE(SAT[gi])) u_dut (
      .C(C), .CLR(CLR), .CE(CE),
      .in_valid(in_valid), .in_ready(rdy_x[gi]),
      .in_a(in_a), .in_b(in_b), .in_last(in_last),
      .mul_a(ma[gi]), .mul_b(mb[gi]), .mul_p(mp[gi]),
      .out_valid(vld_x[gi]), .out_ready(out_ready),
      .out_acc(acc_w), .out_cnt(cnt_x[gi]), .out_ovf(ovf_x[gi])
    );
  end

  int     n_vec = 0;
  int     n_miss = 0;
  int     n_results = 0;
  exp_t   sb [$];
  longint m_acc [NI];
  int     m_cnt [NI];
  bit     m_ovf [NI];
  bit     m_first = 1'b1;
  logic [63:0] last_acc [NI];
  logic [7:0]  last_cnt [NI];
  logic        last_ovf [NI];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_accept(input logic [17:0] a, input logic [17:0] b, input logic last);
    longint p, s, mx, mn;
    exp_t e;
    p = longint'($signed(a)) * longint'($signed(b));
    for (int i = 0; i < NI; i++) begin
      if (m_first) begin
        m_acc[i] = 0;
        m_cnt[i] = 0;
        m_ovf[i] = 1'b0;
      end
      mx = (64'sd1 <<< (AW[i] - 1)) - 1;
      mn = -(64'sd1 <<< (AW[i] - 1));
      s  = m_acc[i] + p;
      if (s > mx || s < mn) begin
        m_ovf[i] = 1'b1;
        if (SAT[i] != 0) s = (s > mx) ? mx : mn;
        else s = (s > mx) ? s - (64'sd1 <<< AW[i]) : s + (64'sd1 <<< AW[i]);
      end
      m_acc[i] = s;
      m_cnt[i] = (m_cnt[i] + 1) % 256;
      e.acc[i] = m_acc[i];
      e.cnt[i] = 8'(m_cnt[i]);
      e.ovf[i] = m_ovf[i];
    end
    m_first = last;
    if (last) sb.push_back(e);
  endtask

  // Handshakes are sampled mid-cycle; inputs only change just after a rising edge.
  always @(negedge C) begin
    if (!CLR) begin
      if (in_valid && rdy_x[0]) model_accept(in_a, in_b, in_last);
      if (vld_x[0] && out_ready) begin
        n_results++;
        if (sb.size() == 0) begin
          check("unexpected_result", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          for (int i = 0; i < NI; i++) begin
            $display("result dut%0d: acc=%0h cnt=%0d ovf=%0d", i, acc_x[i], cnt_x[i], ovf_x[i]);
            check($sformatf("vld%0d", i), 64'(vld_x[i]), 64'd1);
            check($sformatf("acc%0d", i), acc_x[i], e.acc[i]);
            check($sformatf("cnt%0d", i), 64'(cnt_x[i]), 64'(e.cnt[i]));
            check($sformatf("ovf%0d", i), 64'(ovf_x[i]), 64'(e.ovf[i]));
            last_acc[i] = acc_x[i];
            last_cnt[i] = cnt_x[i];
            last_ovf[i] = ovf_x[i];
          end
        end
      end
    end
  end

  task automatic send(input logic [17:0] a, input logic [17:0] b, input logic last);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge C);
      if (rdy_x[0]) done = 1'b1;
    end
    if (!done) check("send_timeout", 64'd0, 64'd1);
    @(posedge C);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 500) begin
      @(posedge C);
      #1;
      k++;
    end
    if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
    repeat (2) @(posedge C);
    #1;
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge C);
      #1;
      if (vld_x[0]) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < NI; i++) begin
      check({tag, "_mul_a"}, 64'(ma[i]), 64'd0);
      check({tag, "_mul_b"}, 64'(mb[i]), 64'd0);
      check({tag, "_acc"}, acc_x[i], 64'd0);
      check({tag, "_cnt"}, 64'(cnt_x[i]), 64'd0);
      check({tag, "_ovf"}, 64'(ovf_x[i]), 64'd0);
      check({tag, "_vld"}, 64'(vld_x[i]), 64'd0);
      check({tag, "_rdy"}, 64'(rdy_x[i]), 64'(CE));
    end
  endtask

  initial begin
    int lat;
    int base;
    CLR = 1'b1; CE = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    in_a = '0; in_b = '0; out_ready = 1'b1;
    #12;
    check_zero("reset");
    #4 CLR = 1'b0;
    @(posedge C);
    #1;

    // Single term; counting the acceptance edge itself, valid shows on the third edge.
    send(18'd3, -18'sd5, 1'b1);
    wait_valid(lat);
    check("t1_latency", 64'(lat), 64'd2);
    drain();
    check("t1_acc", last_acc[0], -64'sd15);
    check("t1_cnt", 64'(last_cnt[0]), 64'd1);

    // Four extreme products: exactly 2^36, which overflows only the 37-bit variants.
    for (int k = 0; k < 4; k++) send(-18'sd131072, -18'sd131072, k == 3);
    drain();
    check("t2_acc48", last_acc[0], 64'h10_0000_0000);
    check("t2_ovf48", 64'(last_ovf[0]), 64'd0);
    check("t3_acc37_wrap", last_acc[1], -64'sh10_0000_0000);
    check("t3_ovf37_wrap", 64'(last_ovf[1]), 64'd1);
    check("t3_acc37_sat", last_acc[2], 64'h0F_FFFF_FFFF);
    check("t3_ovf37_sat", 64'(last_ovf[2]), 64'd1);

    // Backpressure across three single-term groups.
    out_ready = 1'b0;
    base = n_results;
    send(18'd5, 18'd5, 1'b1);
    send(18'd6, 18'd6, 1'b1);
    send(18'd7, 18'd7, 1'b1);
    check("t4_in_ready_drop", 64'(rdy_x[0]), 64'd0);
    repeat (3) @(posedge C);
    #1;
    check("t4_hold_rdy", 64'(rdy_x[0]), 64'd0);
    check("t4_hold_vld", 64'(vld_x[0]), 64'd1);
    check("t4_hold_acc", acc_x[0], 64'd25);
    out_ready = 1'b1;
    drain();
    check("t4_result_count", 64'(n_results - base), 64'd3);
    check("t4_last_acc", last_acc[0], 64'd49);

    // CE dropped for five edges once the group is in flight.
    send(18'd2, 18'd7, 1'b0);
    send(18'd4, -18'sd1, 1'b0);
    send(18'd1, 18'd1, 1'b1);
    CE = 1'b0;
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge C);
      #1;
      if (k == 3) check("t5_in_ready_ce0", 64'(rdy_x[0]), 64'd0);
      if (vld_x[0]) begin
        lat = k;
        break;
      end
      if (k == 5) CE = 1'b1;
    end
    CE = 1'b1;
    check("t5_latency", 64'(lat), 64'd7);
    drain();
    check("t5_acc", last_acc[0], 64'd11);
    check("t5_cnt", 64'(last_cnt[0]), 64'd3);

    // 256-term group wraps the 8-bit counter to zero.
    for (int k = 0; k < 256; k++) send(18'd1, 18'd1, k == 255);
    drain();
    check("cnt_wrap", 64'(last_cnt[0]), 64'd0);
    check("cnt_wrap_acc", last_acc[0], 64'd256);

    // Asynchronous clear mid-group, between edges; the partial group is dropped.
    send(18'd1, 18'd1, 1'b0);
    send(18'd2, 18'd2, 1'b0);
    @(posedge C);
    #2 CLR = 1'b1;
    m_first = 1'b1;
    #1 check_zero("t6_clr");
    #1 CLR = 1'b0;
    @(posedge C);
    #1;
    send(18'd10, 18'd10, 1'b1);
    drain();
    check("t6_acc", last_acc[0], 64'd100);
    check("t6_cnt", 64'(last_cnt[0]), 64'd1);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
